// File: rtl/lsu_mshq_if.sv
// rtl/lsu_mshq_if.sv - store-retire, memory-bus and D$ fill signals of the miss status holding queue
interface lsu_mshq_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DC_LINE_WIDTH = 5
);
    localparam int LINE_BITS = 8 << DC_LINE_WIDTH;

    logic                  sq_retire_en;
    logic                  sq_retire_hit;
    logic [ADDR_WIDTH-1:0] sq_retire_addr;
    logic [DATA_WIDTH-1:0] sq_retire_data;
    logic [3:0]            sq_retire_lsu_func;
    logic                  full;

    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_hit;

    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_fill_valid;
    logic [DATA_WIDTH-1:0] mem_fill_data;

    logic                  dc_fill_en;
    logic [ADDR_WIDTH-1:0] dc_fill_addr;
    logic [LINE_BITS-1:0]  dc_fill_data;

    modport slave (
        input  sq_retire_en, sq_retire_hit, sq_retire_addr, sq_retire_data, sq_retire_lsu_func,
        input  lookup_addr, mem_req_ready, mem_fill_valid, mem_fill_data,
        output full, lookup_hit, mem_req_valid, mem_req_addr, dc_fill_en, dc_fill_addr, dc_fill_data
    );

    modport master (
        output sq_retire_en, sq_retire_hit, sq_retire_addr, sq_retire_data, sq_retire_lsu_func,
        output lookup_addr, mem_req_ready, mem_fill_valid, mem_fill_data,
        input  full, lookup_hit, mem_req_valid, mem_req_addr, dc_fill_en, dc_fill_addr, dc_fill_data
    );
endinterface

// File: rtl/lsu_mshq.sv
// rtl/lsu_mshq.sv - miss status holding queue merging retired store misses and filling D$ lines oldest first
module lsu_mshq #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MSHQ_DEPTH    = 4,
    parameter int DC_LINE_WIDTH = 5
) (
    input logic       clk,
    input logic       n_rst,
    lsu_mshq_if.slave bus
);
    localparam int LINE_BITS  = 8 << DC_LINE_WIDTH;
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int BEATS      = LINE_BITS / DATA_WIDTH;
    localparam int PTR_W      = (MSHQ_DEPTH > 1) ? $clog2(MSHQ_DEPTH) : 1;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W      = ADDR_WIDTH - DC_LINE_WIDTH;

    localparam logic [3:0] FUNC_SB = 4'd0;
    localparam logic [3:0] FUNC_SH = 4'd1;

    typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic [BEAT_W-1:0] beat_cnt;
    logic              mem_req_valid_q;
    logic              dc_fill_en_q;

    logic [MSHQ_DEPTH-1:0] slot_valid;
    logic [TAG_W-1:0]      slot_tag  [MSHQ_DEPTH];
    logic [LINE_BITS-1:0]  slot_data [MSHQ_DEPTH];
    logic [LINE_BYTES-1:0] slot_mask [MSHQ_DEPTH];

    logic [TAG_W-1:0]         st_tag;
    logic [TAG_W-1:0]         lk_tag;
    logic [DC_LINE_WIDTH-1:0] st_off;
    logic [DC_LINE_WIDTH-1:0] st_base;
    logic [LINE_BYTES-1:0]    st_be;
    logic [LINE_BITS-1:0]     st_line;
    logic [MSHQ_DEPTH-1:0]    st_match;
    logic [MSHQ_DEPTH-1:0]    st_write;
    logic                     lookup_hit_c;
    logic                     full_c;
    logic                     accept;
    logic                     merge;
    logic                     alloc;
    logic                     fill_we;
    logic                     unused_ok;

    assign st_tag    = bus.sq_retire_addr[ADDR_WIDTH-1:DC_LINE_WIDTH];
    assign lk_tag    = bus.lookup_addr[ADDR_WIDTH-1:DC_LINE_WIDTH];
    assign unused_ok = ^bus.lookup_addr[DC_LINE_WIDTH-1:0];

    // Store bytes are laid out across the whole line so merge and allocate share one write path
    always_comb begin
        st_off = bus.sq_retire_addr[DC_LINE_WIDTH-1:0];
        case (bus.sq_retire_lsu_func)
            FUNC_SB: begin
                st_base = st_off;
                st_be   = LINE_BYTES'(1) << st_base;
            end
            FUNC_SH: begin
                st_base = {st_off[DC_LINE_WIDTH-1:1], 1'b0};
                st_be   = LINE_BYTES'(3) << st_base;
            end
            default: begin
                st_base = {st_off[DC_LINE_WIDTH-1:2], 2'b00};
                st_be   = LINE_BYTES'(4'hF) << st_base;
            end
        endcase
        st_line = LINE_BITS'(bus.sq_retire_data) << {st_base, 3'b000};
    end

    always_comb begin
        st_match     = '0;
        lookup_hit_c = 1'b0;
        for (int s = 0; s < MSHQ_DEPTH; s++) begin
            st_match[s] = slot_valid[s] && (slot_tag[s] == st_tag);
            if (slot_valid[s] && (slot_tag[s] == lk_tag)) begin
                lookup_hit_c = 1'b1;
            end
        end
    end

    // Blocking during WRITE makes the SQ retry the next cycle, when the line is already in the D$
    assign full_c  = (count == (PTR_W+1)'(MSHQ_DEPTH)) || (state == WRITE);
    assign accept  = bus.sq_retire_en && !bus.sq_retire_hit && !full_c;
    assign merge   = accept && (|st_match);
    assign alloc   = accept && !(|st_match);
    assign fill_we = (state == FILL) && bus.mem_fill_valid;

    always_comb begin
        st_write = '0;
        for (int s = 0; s < MSHQ_DEPTH; s++) begin
            st_write[s] = merge ? st_match[s] : (alloc && (tail == PTR_W'(s)));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            beat_cnt        <= '0;
            slot_valid      <= '0;
            mem_req_valid_q <= 1'b0;
            dc_fill_en_q    <= 1'b0;
        end else begin
            if (alloc) begin
                slot_valid[tail] <= 1'b1;
                tail             <= tail + 1'b1;
                count            <= count + 1'b1;
            end else if (state == WRITE) begin
                count <= count - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state           <= REQ;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state           <= FILL;
                        mem_req_valid_q <= 1'b0;
                        beat_cnt        <= '0;
                    end
                end
                FILL: begin
                    if (bus.mem_fill_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                            state        <= WRITE;
                            dc_fill_en_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    slot_valid[head] <= 1'b0;
                    head             <= head + 1'b1;
                    state            <= IDLE;
                    dc_fill_en_q     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fill bytes land only where no store has written; a same-cycle store still wins
    always_ff @(posedge clk) begin
        for (int s = 0; s < MSHQ_DEPTH; s++) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (fill_we && (head == PTR_W'(s)) && (beat_cnt == BEAT_W'(b / WORD_BYTES))
                        && !slot_mask[s][b]) begin
                    slot_data[s][b*8 +: 8] <= bus.mem_fill_data[(b % WORD_BYTES)*8 +: 8];
                end
                if (st_write[s] && st_be[b]) begin
                    slot_data[s][b*8 +: 8] <= st_line[b*8 +: 8];
                end
            end
            if (alloc && (tail == PTR_W'(s))) begin
                slot_tag[s]  <= st_tag;
                slot_mask[s] <= st_be;
            end else if (st_write[s]) begin
                slot_mask[s] <= slot_mask[s] | st_be;
            end
        end
    end

    assign bus.full          = full_c;
    assign bus.lookup_hit    = lookup_hit_c;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {slot_tag[head], {DC_LINE_WIDTH{1'b0}}};
    assign bus.dc_fill_en    = dc_fill_en_q;
    assign bus.dc_fill_addr  = {slot_tag[head], {DC_LINE_WIDTH{1'b0}}};
    assign bus.dc_fill_data  = slot_data[head];
endmodule

// File: tb/tb_lsu_mshq.sv
// tb/tb_lsu_mshq.sv - vector table, corner sequences and random reference-model check of lsu_mshq
module tb_lsu_mshq;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    lsu_mshq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DC_LINE_WIDTH(5)) bus ();

    lsu_mshq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MSHQ_DEPTH(4), .DC_LINE_WIDTH(5)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_store(input logic hit, input logic [3:0] f, input logic [31:0] a, input logic [31:0] d);
        bus.sq_retire_en       = 1'b1;
        bus.sq_retire_hit      = hit;
        bus.sq_retire_lsu_func = f;
        bus.sq_retire_addr     = a;
        bus.sq_retire_data     = d;
    endtask

    task automatic do_reset();
        bus.sq_retire_en = 1'b0; bus.sq_retire_hit = 1'b0; bus.sq_retire_addr = '0;
        bus.sq_retire_data = '0; bus.sq_retire_lsu_func = '0; bus.lookup_addr = '0;
        bus.mem_req_ready = 1'b0; bus.mem_fill_valid = 1'b0; bus.mem_fill_data = '0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    function automatic logic [31:0] fill_word(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'h1111_1111;
    endfunction

    typedef struct {
        logic [3:0]  f1; logic [31:0] a1; logic [31:0] d1;
        logic        two; int c2;
        logic [3:0]  f2; logic [31:0] a2; logic [31:0] d2;
        logic [31:0] base; logic [31:0] line; int widx; logic [31:0] wexp;
    } vec_t;

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
        logic [31:0]  mask;
    } ent_t;

    function automatic logic [31:0] mem_word(input logic [26:0] tag, input int k);
        return {tag, 5'b0} ^ (32'(k) * 32'h9E37_79B9);
    endfunction

    function automatic logic [255:0] model_line(input ent_t e);
        logic [255:0] r;
        logic [31:0]  w;
        for (int b = 0; b < 32; b++) begin
            w = mem_word(e.tag, b / 4);
            r[b*8 +: 8] = e.mask[b] ? e.data[b*8 +: 8] : w[(b % 4)*8 +: 8];
        end
        return r;
    endfunction

    vec_t         tbl [7];
    vec_t         t;
    ent_t         q [$];
    ent_t         e;
    int           beat, nreq, lat, nwr, sz, base, idx, idle_wait;
    logic         got, hit1, hitw, full_w, flag, check_next_low;
    logic         fill_active, write_now, next_write, prev_pending, full_pred, legal, accepted, lk_exp;
    logic [26:0]  req_tag;
    logic [31:0]  raddr, daddr, w, a, d;
    logic [3:0]   f;
    logic [255:0] dline, exp;
    logic [31:0]  reqs [$];
    logic [31:0]  lines [5];

    initial begin
        tbl[0] = '{4'd2, 32'h1000_0044, 32'hDEAD_BEEF, 1'b0, 0, 4'd0, 32'h0, 32'h0,
                   32'h0000_0000, 32'h1000_0040, 1, 32'hDEAD_BEEF};
        tbl[1] = '{4'd0, 32'h1000_0045, 32'h0000_00AA, 1'b1, 1, 4'd1, 32'h1000_0046, 32'h0000_BBCC,
                   32'h4444_4444, 32'h1000_0040, 1, 32'hBBCC_AA55};
        tbl[2] = '{4'd0, 32'h2000_0000, 32'h0000_0011, 1'b1, 4, 4'd0, 32'h2000_0000, 32'h0000_0077,
                   32'h1234_5678, 32'h2000_0000, 0, 32'h1234_5677};
        tbl[3] = '{4'd0, 32'h1000_0047, 32'hFFFF_FF99, 1'b0, 0, 4'd0, 32'h0, 32'h0,
                   32'h0000_0000, 32'h1000_0040, 1, 32'h9911_1111};
        tbl[4] = '{4'd1, 32'h1000_0063, 32'hABCD_1234, 1'b0, 0, 4'd0, 32'h0, 32'h0,
                   32'h0000_0000, 32'h1000_0060, 0, 32'h1234_0000};
        tbl[5] = '{4'hF, 32'h3000_005E, 32'hCAFE_F00D, 1'b0, 0, 4'd0, 32'h0, 32'h0,
                   32'h0101_0101, 32'h3000_0040, 7, 32'hCAFE_F00D};
        tbl[6] = '{4'd2, 32'h4000_001B, 32'h5A5A_0F0F, 1'b0, 0, 4'd0, 32'h0, 32'h0,
                   32'h1010_1010, 32'h4000_0000, 6, 32'h5A5A_0F0F};

        do_reset();
        #1;
        chk("reset_full", bus.full, 1'b0);
        chk("reset_req_valid", bus.mem_req_valid, 1'b0);
        chk("reset_fill_en", bus.dc_fill_en, 1'b0);
        chk("reset_lookup", bus.lookup_hit, 1'b0);

        for (int v = 0; v < 7; v++) begin
            t = tbl[v];
            do_reset();
            bus.mem_req_ready = 1'b1;
            bus.lookup_addr   = t.line | 32'h1C;
            beat = -1; nreq = 0; got = 1'b0; lat = -1; raddr = '0; daddr = '0; dline = '0;
            hit1 = 1'b0; hitw = 1'b0; full_w = 1'b0;
            for (int c = 0; c < 30 && !got; c++) begin
                if (c == 0) set_store(1'b0, t.f1, t.a1, t.d1);
                else if (t.two && c == t.c2) set_store(1'b0, t.f2, t.a2, t.d2);
                else bus.sq_retire_en = 1'b0;
                bus.mem_fill_valid = (beat >= 0 && beat < BEATS);
                bus.mem_fill_data  = fill_word(t.base, beat);
                #1;
                if (c == 1) hit1 = bus.lookup_hit;
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    nreq++; raddr = bus.mem_req_addr; beat = 0;
                end else if (beat >= 0 && beat < BEATS) begin
                    beat++;
                end
                if (bus.dc_fill_en) begin
                    got = 1'b1; lat = c; daddr = bus.dc_fill_addr; dline = bus.dc_fill_data;
                    full_w = bus.full; hitw = bus.lookup_hit;
                end
                @(negedge clk);
            end
            for (int k = 0; k < BEATS; k++) begin
                w = (k == t.widx) ? t.wexp : fill_word(t.base, k);
                exp[k*32 +: 32] = w;
            end
            chk($sformatf("v%0d_req_count", v), nreq, 1);
            chk($sformatf("v%0d_req_addr", v), raddr, t.line);
            chk($sformatf("v%0d_fill_seen", v), got, 1'b1);
            chk($sformatf("v%0d_latency", v), lat, 11);
            chk($sformatf("v%0d_fill_addr", v), daddr, t.line);
            chk($sformatf("v%0d_fill_line", v), dline, exp);
            chk($sformatf("v%0d_full_in_write", v), full_w, 1'b1);
            chk($sformatf("v%0d_lookup_pending", v), hit1, 1'b1);
            chk($sformatf("v%0d_lookup_in_write", v), hitw, 1'b1);
            bus.sq_retire_en = 1'b0; bus.mem_fill_valid = 1'b0;
            flag = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                flag = flag | bus.mem_req_valid | bus.dc_fill_en | bus.full | bus.lookup_hit;
                @(negedge clk);
            end
            chk($sformatf("v%0d_post_write_quiet", v), flag, 1'b0);
        end

        // reset in the middle of a fill
        do_reset();
        bus.mem_req_ready = 1'b1;
        bus.lookup_addr   = 32'h5000_0008;
        set_store(1'b0, 4'd2, 32'h5000_0004, 32'h0000_0001);
        @(negedge clk); bus.sq_retire_en = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.mem_fill_valid = 1'b1; bus.mem_fill_data = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1; chk("pre_reset_lookup", bus.lookup_hit, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_fill_en", bus.dc_fill_en, 1'b0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_lookup", bus.lookup_hit, 1'b0);
        @(negedge clk); n_rst = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1; flag = flag | bus.dc_fill_en | bus.mem_req_valid | bus.full;
            @(negedge clk);
        end
        chk("rst_fill_ignored", flag, 1'b0);

        // fill all slots, fifth miss refused, requests in allocation order
        do_reset();
        for (int i = 0; i < 5; i++) lines[i] = 32'h6000_0000 + 32'(i) * 32'h40;
        for (int i = 0; i < 4; i++) begin
            set_store(1'b0, 4'd2, lines[i] + 32'(4 * i), 32'h100 + 32'(i));
            @(negedge clk);
        end
        set_store(1'b0, 4'd2, lines[4], 32'h999);
        #1; chk("full_at_depth", bus.full, 1'b1);
        @(negedge clk);
        bus.sq_retire_en = 1'b0;
        bus.mem_req_ready = 1'b1;
        beat = -1; nwr = 0; check_next_low = 1'b0; reqs.delete();
        for (int c = 0; c < 80 && nwr < 4; c++) begin
            bus.mem_fill_valid = (beat >= 0 && beat < BEATS);
            bus.mem_fill_data  = 32'(c);
            #1;
            if (check_next_low) begin
                chk("full_after_write", bus.full, 1'b0);
                check_next_low = 1'b0;
            end
            if (bus.mem_req_valid) begin
                reqs.push_back(bus.mem_req_addr); beat = 0;
            end else if (beat >= 0 && beat < BEATS) begin
                beat++;
            end
            if (bus.dc_fill_en) begin
                nwr++;
                chk($sformatf("full_wr_addr%0d", nwr), bus.dc_fill_addr, lines[nwr-1]);
                if (nwr == 1) begin
                    chk("full_in_first_write", bus.full, 1'b1);
                    check_next_low = 1'b1;
                end
            end
            @(negedge clk);
        end
        chk("full_writes", nwr, 4);
        chk("full_req_count", reqs.size(), 4);
        for (int i = 0; i < 4 && i < reqs.size(); i++) chk($sformatf("req_order%0d", i), reqs[i], lines[i]);
        bus.lookup_addr = lines[4];
        #1; chk("fifth_not_taken", bus.lookup_hit | bus.mem_req_valid, 1'b0);
        @(negedge clk);

        // D$ hits never enter the queue
        do_reset();
        bus.mem_req_ready = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_store(1'b1, 4'd2, 32'h7000_0000 + 32'(i) * 32'h40, 32'(i));
            @(negedge clk);
        end
        bus.sq_retire_en = 1'b0;
        bus.lookup_addr  = 32'h7000_0000;
        for (int c = 0; c < 4; c++) begin
            #1; flag = flag | bus.mem_req_valid | bus.full | bus.lookup_hit;
            @(negedge clk);
        end
        chk("hit_ignored", flag, 1'b0);

        // random traffic against the queue-level reference model
        do_reset();
        q.delete();
        fill_active = 1'b0; write_now = 1'b0; next_write = 1'b0; prev_pending = 1'b0;
        beat = 0; idle_wait = 0; req_tag = '0;
        for (int c = 0; c < 3000; c++) begin
            a = {27'h048_0000 + 27'($urandom % 6), 5'($urandom)};
            d = $urandom;
            case ($urandom % 5)
                0: f = 4'd0;
                1: f = 4'd1;
                2: f = 4'd2;
                3: f = 4'd3;
                default: f = 4'hF;
            endcase
            bus.sq_retire_en       = ($urandom % 3) != 0;
            bus.sq_retire_hit      = ($urandom % 4) == 0;
            bus.sq_retire_addr     = a;
            bus.sq_retire_data     = d;
            bus.sq_retire_lsu_func = f;
            bus.lookup_addr        = {27'h048_0000 + 27'($urandom % 6), 5'($urandom)};
            bus.mem_req_ready      = $urandom % 2;
            bus.mem_fill_valid     = fill_active ? (($urandom % 4) != 0) : (($urandom % 8) == 0);
            bus.mem_fill_data      = fill_active ? mem_word(req_tag, beat) : $urandom;
            #1;
            full_pred = (q.size() == 4) || write_now;
            chk("rnd_full", bus.full, full_pred);
            lk_exp = 1'b0;
            foreach (q[i]) if (q[i].tag == bus.lookup_addr[31:5]) lk_exp = 1'b1;
            chk("rnd_lookup", bus.lookup_hit, lk_exp);
            chk("rnd_fill_en", bus.dc_fill_en, write_now);
            if (write_now && q.size() > 0) begin
                chk("rnd_fill_addr", bus.dc_fill_addr, {q[0].tag, 5'b0});
                chk("rnd_fill_line", bus.dc_fill_data, model_line(q[0]));
            end
            legal = 1'b0;
            if (bus.mem_req_valid) begin
                legal = (q.size() > 0) && !fill_active && !write_now && (bus.mem_req_addr == {q[0].tag, 5'b0});
                chk("rnd_req_legal", legal, 1'b1);
            end
            if (prev_pending) chk("rnd_req_hold", bus.mem_req_valid, 1'b1);
            if (q.size() > 0 && !fill_active && !write_now && !bus.mem_req_valid) idle_wait++;
            else idle_wait = 0;
            chk("rnd_req_timely", idle_wait <= 1, 1'b1);
            prev_pending = bus.mem_req_valid && !bus.mem_req_ready;

            accepted = bus.sq_retire_en && !bus.sq_retire_hit && !full_pred;
            if (accepted) begin
                sz   = (f == 4'd0) ? 1 : (f == 4'd1) ? 2 : 4;
                base = int'(a[4:0]) & ~(sz - 1);
                idx  = -1;
                foreach (q[i]) if (q[i].tag == a[31:5]) idx = i;
                if (idx < 0) begin
                    e.tag = a[31:5]; e.data = '0; e.mask = '0;
                    q.push_back(e);
                    idx = q.size() - 1;
                end
                e = q[idx];
                for (int j = 0; j < sz; j++) begin
                    e.data[(base + j)*8 +: 8] = d[j*8 +: 8];
                    e.mask[base + j] = 1'b1;
                end
                q[idx] = e;
            end
            if (fill_active && bus.mem_fill_valid) begin
                beat++;
                if (beat == BEATS) begin
                    fill_active = 1'b0;
                    next_write  = 1'b1;
                end
            end
            if (bus.mem_req_valid && bus.mem_req_ready && legal) begin
                fill_active = 1'b1; beat = 0; req_tag = q[0].tag;
            end
            if (write_now && q.size() > 0) void'(q.pop_front());
            write_now  = next_write;
            next_write = 1'b0;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_mshq.md
Name: lsu_mshq

Overview:
- Miss Status Holding Queue.
- Receives retired-store misses from the store queue's retire port and merges stores to the same cache line.
- Fetches each missing line from memory, oldest first, one request outstanding.
- Writes the merged line (fill bytes overlaid by store bytes) into the D$ in one cycle.
- Sits between the LSU store-retire path, the memory bus and the D$ fill port. Its full signal back-pressures ROB store retirement.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, store data width and memory fill beat width
- MSHQ_DEPTH, 4, number of slots (power of 2)
- DC_LINE_WIDTH, 5, log2 line size in bytes; LINE_BITS = 8<<DC_LINE_WIDTH, BEATS = LINE_BITS/DATA_WIDTH

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- i_sq_retire_en  in  1  store retiring this cycle
- i_sq_retire_hit  in  1  retiring store hit in D$ (ignore request)
- i_sq_retire_addr  in  ADDR_WIDTH  store byte address
- i_sq_retire_data  in  DATA_WIDTH  store data, right-aligned
- i_sq_retire_lsu_func  in  4  lsu_func_t (SB/SH/SW)
- o_full  out  1  cannot accept a store miss this cycle (drives SQ mshq_full)
- i_lookup_addr  in  ADDR_WIDTH  probe address
- o_lookup_hit  out  1  a valid slot holds the probed line (combinational)
- o_mem_req_valid  out  1  line read request
- o_mem_req_addr  out  ADDR_WIDTH  line-aligned address (low DC_LINE_WIDTH bits 0)
- i_mem_req_ready  in  1  memory accepts request
- i_mem_fill_valid  in  1  fill beat valid
- i_mem_fill_data  in  DATA_WIDTH  fill beat, ascending word order
- o_dc_fill_en  out  1  write line to D$
- o_dc_fill_addr  out  ADDR_WIDTH  line-aligned address
- o_dc_fill_data  out  LINE_BITS  merged line

Behaviour:

Slot contents:
- valid, line address (ADDR_WIDTH-DC_LINE_WIDTH bits), LINE_BITS data, LINE_BITS/8 byte mask.
- Slots form a circular FIFO with head, tail and count registers.

Store acceptance:
- A store is accepted when i_sq_retire_en && ~i_sq_retire_hit && ~o_full.
- Otherwise the store is ignored. No state changes when hit=1.
- Merge: if any valid slot matches the store's line, including the head slot while in FILL, write the store bytes into that slot's data and set its mask bits. No new allocation.
- No match: allocate at tail with mask cleared except the store bytes. Increment tail and count.
- Byte placement uses offset addr[DC_LINE_WIDTH-1:0]:
  - SB: 1 byte.
  - SH: 2 bytes at the offset with bit 0 forced to 0.
  - SW: 4 bytes at the offset with bits 1:0 forced to 0.
  - Any other func is treated as SW.
- Accepted store is visible to o_lookup_hit the next cycle.
- o_full = (count == MSHQ_DEPTH) || (state == WRITE).
  - Blocking during WRITE forces the SQ to retry one cycle later, when the D$ hits.

FSM states: IDLE, REQ, FILL, WRITE.
- IDLE: if count != 0, go to REQ next cycle.
- REQ:
  - o_mem_req_valid = 1; o_mem_req_addr = head line address.
  - Valid and address hold stable until i_mem_req_ready.
  - Handshake (valid && ready) moves to FILL and clears beat_cnt.
- FILL:
  - Each i_mem_fill_valid writes beat into head word beat_cnt, only bytes whose mask bit is 0. beat_cnt increments.
  - On beat BEATS-1, go to WRITE.
  - i_mem_fill_valid in any other state is ignored.
- WRITE (exactly one cycle):
  - o_dc_fill_en = 1, o_dc_fill_addr = head line, o_dc_fill_data = head data.
  - Clear head valid, increment head, decrement count, return to IDLE.

Other rules:
- Pointers wrap modulo MSHQ_DEPTH. count is $clog2(MSHQ_DEPTH)+1 bits.
- No flush input: stores accepted here are architecturally retired and must complete.
- Reset, including mid-request or mid-fill:
  - state = IDLE; all valid = 0; head = tail = count = beat_cnt = 0.
  - o_full = 0, o_mem_req_valid = 0, o_dc_fill_en = 0.
  - o_lookup_hit = 0.
  - Addresses and data are don't-care.
- Minimum latency from accepting the first miss to o_dc_fill_en is 3 + BEATS cycles with ready and fill always asserted.

Test Plan:
- Reset: assert n_rst=0 mid-FILL -> o_mem_req_valid=0, o_dc_fill_en=0, o_full=0; subsequent fill beats ignored.
- Single miss: SW addr 0x1000_0044 data 0xDEADBEEF, hit=0 -> o_mem_req_addr=0x1000_0040. Fill beats k=0..7 data 0x1111_1111*k -> one-cycle o_dc_fill_en, addr 0x1000_0040, word1=0xDEADBEEF, word k=0x1111_1111*k otherwise.
- Merge: SB 0x1000_0045 data 0xAA, then SH 0x1000_0046 data 0xBBCC, both before REQ handshake -> exactly one request. Fill word1=0x5555_5555 -> D$ word1=0xBBCC_AA55.
- Merge during FILL: SB 0x2000_0000 data 0x77 after beat 0 accepted with 0x1234_5678 -> D$ word0=0x1234_5677.
- Full: 4 misses to distinct lines -> o_full=1; 5th store (distinct line) not accepted. After first WRITE, the o_full pattern holds: high in WRITE, then low. Requests issue in allocation order.
- Hit ignored and lookup: retire_en=1, hit=1 -> no request, count unchanged. o_lookup_hit=1 for any address in a pending line; 0 after that line's WRITE.
